// File: rtl/fft_frame_scheduler_pkg.sv
// rtl/fft_frame_scheduler_pkg.sv - shared types for the FFT frame scheduler
// Sample, tag and state types used by the scheduler, its interface and the bench.
package fft_frame_scheduler_pkg;

   localparam int CPLX_W    = 16;
   localparam int TAG_FID_W = 8;

   typedef struct packed {
      logic signed [CPLX_W-1:0] re;
      logic signed [CPLX_W-1:0] im;
   } complex_product_t;

   typedef struct packed {
      logic                 src;
      logic [TAG_FID_W-1:0] fid;
   } fft_tag_t;

   typedef enum logic {
      SCH_IDLE = 1'b0,
      SCH_LOAD = 1'b1
   } sch_state_t;

   function automatic logic [1:0] src_onehot(input logic src);
      return src ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/fft_frame_scheduler_if.sv
// rtl/fft_frame_scheduler_if.sv - source, core and result signals of the frame scheduler
// The scheduler uses the slave view; front ends, core model and bench use the master view.
interface fft_frame_scheduler_if
   import fft_frame_scheduler_pkg::*;
#(
   parameter int FID_W = TAG_FID_W
);
   logic [1:0]             s_valid;
   logic [1:0]             s_ready;
   complex_product_t [1:0] s_data_0;
   complex_product_t [1:0] s_data_1;
   logic                   core_enable;
   complex_product_t       core_data_in_0;
   complex_product_t       core_data_in_1;
   logic                   core_out_valid;
   logic                   result_valid;
   logic                   result_src;
   logic [FID_W-1:0]       result_fid;
   logic                   busy;
   logic                   tag_error;

   modport master (
      output s_valid, s_data_0, s_data_1, core_out_valid,
      input  s_ready, core_enable, core_data_in_0, core_data_in_1,
      input  result_valid, result_src, result_fid, busy, tag_error
   );

   modport slave (
      input  s_valid, s_data_0, s_data_1, core_out_valid,
      output s_ready, core_enable, core_data_in_0, core_data_in_1,
      output result_valid, result_src, result_fid, busy, tag_error
   );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
// A push into a full FIFO is taken only when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             empty
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
      return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fft_frame_scheduler.sv
// rtl/fft_frame_scheduler.sv - frame-granular round-robin sharing of one FFT core by two streams
// Each granted frame is registered into the core and tagged so results map back to source/frame.
module fft_frame_scheduler
   import fft_frame_scheduler_pkg::*;
#(
   parameter int N         = 8,
   parameter int TAG_DEPTH = 4,
   parameter int FID_W     = TAG_FID_W
) (
   input  logic                  clk,
   input  logic                  reset,
   fft_frame_scheduler_if.slave  bus
);
   localparam int BEATS  = N / 2;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CW     = $clog2(TAG_DEPTH + 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   sch_state_t        state;
   sch_state_t        state_next;
   logic              grant;
   logic              grant_next;
   logic              rr_ptr;
   logic [BEAT_W-1:0] beat_cnt;
   logic [FID_W-1:0]  fid_cnt [2];
   logic [1:0]        ready_vec;
   logic              accept;
   logic              last_beat;

   logic              core_en_q;
   complex_product_t  core_d0_q;
   complex_product_t  core_d1_q;
   logic              tag_error_q;

   fft_tag_t          push_tag;
   fft_tag_t          head_tag;
   logic [CW-1:0]     tag_count;
   logic              tag_empty;
   logic              result_fire;

   // Grant needs a free tag slot; with one frame loading at a time the last-beat push cannot overflow.
   always_comb begin
      state_next = state;
      grant_next = grant;
      ready_vec  = 2'b00;
      accept     = 1'b0;
      last_beat  = 1'b0;
      case (state)
         SCH_IDLE: begin
            if ((|bus.s_valid) && (tag_count < CW'(TAG_DEPTH))) begin
               grant_next = (&bus.s_valid) ? rr_ptr : bus.s_valid[1];
               state_next = SCH_LOAD;
            end
         end
         SCH_LOAD: begin
            ready_vec = src_onehot(grant);
            accept    = bus.s_valid[grant];
            last_beat = accept && (beat_cnt == LAST_BEAT);
            if (last_beat) begin
               state_next = SCH_IDLE;
            end
         end
         default: state_next = SCH_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SCH_IDLE;
         grant <= 1'b0;
      end else begin
         state <= state_next;
         grant <= grant_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr      <= 1'b0;
         beat_cnt    <= '0;
         fid_cnt[0]  <= '0;
         fid_cnt[1]  <= '0;
         core_en_q   <= 1'b0;
         core_d0_q   <= '0;
         core_d1_q   <= '0;
         tag_error_q <= 1'b0;
      end else begin
         core_en_q <= accept;
         if (accept) begin
            core_d0_q <= bus.s_data_0[grant];
            core_d1_q <= bus.s_data_1[grant];
            beat_cnt  <= last_beat ? '0 : beat_cnt + 1'b1;
         end
         if (last_beat) begin
            fid_cnt[grant] <= fid_cnt[grant] + 1'b1;
            rr_ptr         <= ~grant;
         end
         if (bus.core_out_valid && tag_empty) begin
            tag_error_q <= 1'b1;
         end
      end
   end

   assign push_tag = '{src: grant, fid: fid_cnt[grant]};

   sync_fifo #(
      .WIDTH ($bits(fft_tag_t)),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (last_beat),
      .push_data (push_tag),
      .pop       (result_fire),
      .head      (head_tag),
      .count     (tag_count),
      .empty     (tag_empty)
   );

   assign result_fire = bus.core_out_valid & ~tag_empty;

   assign bus.s_ready        = ready_vec;
   assign bus.busy           = (state == SCH_LOAD);
   assign bus.core_enable    = core_en_q;
   assign bus.core_data_in_0 = core_d0_q;
   assign bus.core_data_in_1 = core_d1_q;
   assign bus.result_valid   = result_fire;
   // Head is forced to zero while empty so the result fields never expose stale FIFO contents.
   assign bus.result_src     = tag_empty ? 1'b0 : head_tag.src;
   assign bus.result_fid     = tag_empty ? '0 : head_tag.fid;
   assign bus.tag_error      = tag_error_q;

endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
Shares one radix-2 N-point FFT core (fft_N_rad2) between two sample streams, one per receive antenna. Arbitrates at frame granularity and streams each granted frame into the core's two-sample-per-cycle input. Tags every frame so the core's out_valid pulse can be attributed to its source stream and frame number. Sits between the per-antenna front ends and the FFT core in the MIMO-OFDM receive path.

Parameters:
N, 8, FFT size; power of 2, at least 4; a frame is N/2 beats of two samples each
TAG_DEPTH, 4, frames that may be in flight inside the core (tag FIFO depth); power of 2
FID_W, 8, width of the per-source frame counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
s_valid  in  2  per-source beat valid
s_ready  out  2  per-source beat ready
s_data_0  in  2 x complex_product_t  per-source even sample of the beat
s_data_1  in  2 x complex_product_t  per-source odd sample of the beat
core_enable  out  1  registered; high for one cycle per beat presented to the core
core_data_in_0  out  complex_product_t  registered even sample to the core
core_data_in_1  out  complex_product_t  registered odd sample to the core
core_out_valid  in  1  core result-frame valid
result_valid  out  1  core_out_valid qualified by a non-empty tag FIFO
result_src  out  1  source of the frame now leaving the core
result_fid  out  FID_W  that source's frame number
busy  out  1  high in LOAD
tag_error  out  1  sticky; set when core_out_valid arrives with the tag FIFO empty

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr=0, beat_cnt=0, both fid counters 0, tag FIFO empty.
- Interface rule: one clock, clk; reset is synchronous and active-high, port name reset.
- States: IDLE, LOAD.
- IDLE: at least one s_valid high and tag count < TAG_DEPTH -> register grant g, go to LOAD.
  - Both sources valid: g = rr_ptr.
  - One source valid: g = that source.
  - Tag FIFO full: stay in IDLE, s_ready=0.
- LOAD:
  - s_ready[g]=1; s_ready[!g]=0.
  - A beat is accepted when s_valid[g] & s_ready[g].
  - The cycle after each accepted beat: core_enable=1, with core_data_in_0/1 = the accepted samples.
  - s_valid low mid-frame: no beat is accepted and core_enable is 0 the next cycle. The frame stays locked to g; no timeout.
  - beat_cnt increments per accepted beat.
- Last beat (beat_cnt == N/2-1, accepted):
  - push tag {g, fid[g]}; fid[g] wraps at 2^FID_W;
  - rr_ptr = !g; beat_cnt = 0; go to IDLE.
  - Earliest next grant is the following cycle, so there is one idle cycle between frames at the core input.
- Space guarantee: grant requires free tag space and only one frame loads at a time, so the push on the last beat never overflows.
- Result side:
  - result_valid = core_out_valid & !empty (combinational).
  - result_src/result_fid show the FIFO head; pop when result_valid.
  - core_out_valid with FIFO empty: no pop, result_valid=0, tag_error=1 until reset.
- Push and pop in the same cycle: both happen, count unchanged, correct at every occupancy.
- Reset mid-frame:
  - the partial frame is abandoned and no tag is pushed;
  - core_enable drops on the cycle after reset is sampled;
  - the core shares the reset, so no stale results return.
- Core latency is not modelled; ordering is FIFO because the core is in-order.

Decomposition:
- The shared headers package already provides complex_product_t. Add to it:
  - fft_tag_t struct {logic src; logic [FID_W-1:0] fid;}
  - a state enum {SCH_IDLE, SCH_LOAD}.
- One sub-module: sync_fifo (parameterised width/depth, count, full/empty) holding the tags.
- Arbiter, beat counter and input registers stay in fft_frame_scheduler.

Test Plan:
- Source 0 only, s_valid held high, N=8 -> s_ready[0]=1 for 4 beats starting the cycle after the grant, then 1 cycle low. core_enable high for 4 consecutive cycles with in-order data. Core returns out_valid -> result_src=0, result_fid=0.
- Both sources continuously valid from reset -> grants alternate 0,1,0,1. result_fid per source 0,1,... and result order matches issue order.
- Source 0 drops s_valid on beat 2 for 3 cycles -> core_enable has a 3-cycle gap. Source 1 is not granted until source 0's 4th beat. Exactly one tag is pushed.
- core_out_valid held low, TAG_DEPTH=4 -> 4 frames accepted, then s_ready=0 with busy=0. One core_out_valid pulse -> the next grant follows within 2 cycles.
- Reset asserted on beat 2 of a frame -> next cycle all outputs 0 and FIFO empty. After release, the first grant reports fid=0.
- core_out_valid with FIFO empty -> result_valid=0, tag_error=1 and remains 1 until reset.
